// File: rtl/ripple_seq_pkg.sv
// ripple_seq_pkg
//  Shared definitions for the ripple_add_sequencer slice.
//  - NIBBLE_W : width of the time-shared nibble adder.
//  - state_t  : sequencer FSM encoding (IDLE, ADD, DONE).
package ripple_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_rca.sv
// nibble_rca
//  Purely combinational 4-bit ripple-carry adder built from full-adder cells.
//  Ports:
//    a, b  in  [3:0]  addends
//    cin   in         carry into bit 0
//    sum   out [3:0]  a + b + cin, modulo 16
//    cout  out        carry out of bit 3
module nibble_rca
  import ripple_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // carry[i] is the carry into bit i; carry[NIBBLE_W] leaves the nibble.
  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/ripple_add_sequencer.sv
// ripple_add_sequencer
//  Multi-cycle wide adder that time-shares one nibble_rca across a
//  4*NIBBLES-bit operation, LSB nibble first, with a registered carry
//  between nibbles. Operands arrive on a valid/ready port and the sum
//  leaves on a valid/ready port.
//  Optional feature macro: ADD_SUB_EN (adds op_sub input; 1 = a - b).
//  Ports:
//    clk        in       rising-edge clock
//    rst        in       synchronous active-high reset
//    in_valid   in       operands valid
//    in_ready   out      ready for operands (IDLE only, low during rst)
//    a, b       in  [W]  operands
//    cin        in       carry into nibble 0
//    op_sub     in       (ADD_SUB_EN only) subtract b from a
//    out_valid  out      sum/cout valid, held until out_ready
//    out_ready  in       consumer accepts result
//    sum        out [W]  registered result, modulo 2^W
//    cout       out      registered carry out of top nibble
module ripple_add_sequencer
  import ripple_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NIBBLES-1:0]    a,
  input  logic [4*NIBBLES-1:0]    b,
  input  logic                    cin,
`ifdef ADD_SUB_EN
  input  logic                    op_sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NIBBLES-1:0]    sum,
  output logic                    cout
);

  localparam int W    = NIBBLE_W * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state_reg, state_next;
  logic [W-1:0]        a_reg, b_reg;
  logic [W-1:0]        sum_reg;
  logic                cout_reg;
  logic                carry_reg;
  logic [IDXW-1:0]     idx_reg;
  logic                sub_reg;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;
  logic                last_nib;

  assign last_nib = (idx_reg == IDXW'(NIBBLES - 1));

  // Subtraction is a + ~b + 1: each b nibble is inverted on its way into
  // the adder and the carry chain is seeded with 1 at accept time.
  assign nib_a = a_reg[idx_reg*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_reg[idx_reg*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_reg}};

  nibble_rca u_nibble_rca (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_reg),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid && in_ready) state_next = ADD;
      ADD:     if (last_nib)             state_next = DONE;
      DONE:    if (out_ready)            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; out_valid is registered by virtue of state_reg.
  always_comb begin
    in_ready  = (state_reg == IDLE) && !rst;
    out_valid = (state_reg == DONE);
  end

  // Datapath: operand latch, nibble index, inter-nibble carry, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sub_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg   <= a;
            b_reg   <= b;
            idx_reg <= '0;
`ifdef ADD_SUB_EN
            sub_reg   <= op_sub;
            carry_reg <= op_sub ? 1'b1 : cin;
`else
            sub_reg   <= 1'b0;
            carry_reg <= cin;
`endif
          end
        end
        ADD: begin
          sum_reg[idx_reg*NIBBLE_W +: NIBBLE_W] <= nib_sum;
          carry_reg <= nib_cout;
          if (last_nib) begin
            cout_reg <= nib_cout;
            idx_reg  <= '0;
          end else begin
            idx_reg  <= idx_reg + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
